sys_bridge: RTL and testbench

SYS_BRIDGE -- requirements
Module: sys_bridge

---
 rtl/bridge_pkg.sv | 13 +
 rtl/bridge_decode.sv | 34 +++
 rtl/sys_bridge.sv | 160 ++++++++++++++++
 tb/tb_sys_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared FSM state type and default address-window map for the system bridge.
package bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_7F00;
   localparam int          DEF_WIN_BITS  = 4;

endpackage

// File: rtl/bridge_decode.sv
// Address decoder: maps a CPU address onto one of NUM_DEV consecutive windows.
module bridge_decode
   import bridge_pkg::*;
#(
   parameter int          NUM_DEV   = 2,
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          WIN_BITS  = DEF_WIN_BITS
) (
   input  logic [31:0]        addr,
   output logic [NUM_DEV-1:0] sel,
   output logic               hit
);

   localparam logic [31:0] BASE_IDX = BASE_ADDR >> WIN_BITS;

   logic [31:0] win_idx_s;

   assign win_idx_s = addr >> WIN_BITS;

   // one-hot window match, at most one bit set because windows are disjoint
   always_comb begin
      sel = {NUM_DEV{1'b0}};
      for (int k = 0; k < NUM_DEV; k++) begin
         if (win_idx_s == BASE_IDX + 32'(k)) begin
            sel[k] = 1'b1;
         end else begin
            sel[k] = 1'b0;
         end
      end
   end

   assign hit = |sel;

endmodule

// File: rtl/sys_bridge.sv
// CPU-to-device bridge with windowed address decode and registered interrupt pass-through.
// Optional ACCESS timeout is built when BRIDGE_TIMEOUT_EN is defined.
module sys_bridge
   import bridge_pkg::*;
#(
   parameter int          NUM_DEV   = 2,
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int          WIN_BITS  = DEF_WIN_BITS,
   parameter int          NUM_IRQ   = 6,
   parameter int          TIMEOUT   = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [31:0]             cpu_addr,
   input  logic [31:0]             cpu_wdata,
   output logic [31:0]             cpu_rdata,
   output logic                    cpu_ready,
   output logic                    cpu_err,
   output logic [NUM_DEV-1:0]      dev_sel,
   output logic [NUM_DEV-1:0]      dev_we,
   output logic [31:0]             dev_addr,
   output logic [31:0]             dev_wdata,
   input  logic [NUM_DEV*32-1:0]   dev_rdata,
   input  logic [NUM_DEV-1:0]      dev_ready,
   input  logic [NUM_IRQ-1:0]      irq_in,
   output logic [NUM_IRQ-1:0]      hwint_out
);

   state_t             state_r;
   logic               we_r;
   logic [NUM_DEV-1:0] dec_sel_s;
   logic               dec_hit_s;
   logic               sel_ready_s;
   logic [31:0]        sel_rdata_s;
   logic               tmo_s;

   bridge_decode #(
      .NUM_DEV   (NUM_DEV),
      .BASE_ADDR (BASE_ADDR),
      .WIN_BITS  (WIN_BITS)
   ) u_decode (
      .addr (cpu_addr),
      .sel  (dec_sel_s),
      .hit  (dec_hit_s)
   );

   // read data of the granted device; dev_sel is one-hot or zero
   always_comb begin
      sel_rdata_s = 32'h0000_0000;
      for (int k = 0; k < NUM_DEV; k++) begin
         if (dev_sel[k]) begin
            sel_rdata_s = sel_rdata_s | dev_rdata[32*k +: 32];
         end else begin
            sel_rdata_s = sel_rdata_s;
         end
      end
   end

   assign sel_ready_s = |(dev_ready & dev_sel);

`ifdef BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] tmo_cnt_r;

   assign tmo_s = (tmo_cnt_r == CNT_W'(TIMEOUT - 1));

   // counts ACCESS cycles, restarted on every entry into ACCESS
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == IDLE && cpu_req && dec_hit_s) begin
         tmo_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ACCESS && !tmo_s) begin
         tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end
`else
   assign tmo_s = 1'b0;
`endif

   // bridge FSM; every CPU/device output is a register written only here
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         we_r      <= 1'b0;
         cpu_ready <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= 32'h0000_0000;
         dev_sel   <= {NUM_DEV{1'b0}};
         dev_we    <= {NUM_DEV{1'b0}};
         dev_addr  <= 32'h0000_0000;
         dev_wdata <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               cpu_ready <= 1'b0;
               if (cpu_req) begin
                  we_r      <= cpu_we;
                  dev_addr  <= cpu_addr;
                  dev_wdata <= cpu_wdata;
                  if (dec_hit_s) begin
                     state_r <= ACCESS;
                     dev_sel <= dec_sel_s;
                     dev_we  <= dec_sel_s & {NUM_DEV{cpu_we}};
                  end else begin
                     state_r   <= RESP;
                     cpu_ready <= 1'b1;
                     cpu_err   <= 1'b1;
                     cpu_rdata <= 32'h0000_0000;
                  end
               end
            end
            ACCESS: begin
               if (sel_ready_s) begin
                  state_r   <= RESP;
                  cpu_ready <= 1'b1;
                  cpu_err   <= 1'b0;
                  cpu_rdata <= we_r ? 32'h0000_0000 : sel_rdata_s;
                  dev_sel   <= {NUM_DEV{1'b0}};
                  dev_we    <= {NUM_DEV{1'b0}};
               end else if (tmo_s) begin
                  state_r   <= RESP;
                  cpu_ready <= 1'b1;
                  cpu_err   <= 1'b1;
                  cpu_rdata <= 32'h0000_0000;
                  dev_sel   <= {NUM_DEV{1'b0}};
                  dev_we    <= {NUM_DEV{1'b0}};
               end else begin
                  state_r <= ACCESS;
               end
            end
            RESP: begin
               cpu_ready <= 1'b0;
               state_r   <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               cpu_ready <= 1'b0;
               dev_sel   <= {NUM_DEV{1'b0}};
               dev_we    <= {NUM_DEV{1'b0}};
            end
         endcase
      end
   end

   // interrupt lines are re-timed by a single register stage
   always_ff @(posedge clk) begin
      if (reset) begin
         hwint_out <= {NUM_IRQ{1'b0}};
      end else begin
         hwint_out <= irq_in;
      end
   end

endmodule

// File: tb/tb_sys_bridge.sv
// Directed bench for sys_bridge: a transaction-level model checked every cycle plus literal checkpoints.
module tb_sys_bridge;

   localparam int          NUM_DEV  = 2;
   localparam logic [31:0] BASE     = 32'h0000_7F00;
   localparam int          WIN_BITS = 4;
   localparam int          NUM_IRQ  = 6;
   localparam int          TIMEOUT  = 15;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  cpu_req, cpu_we;
   logic [31:0]           cpu_addr, cpu_wdata;
   logic [31:0]           cpu_rdata;
   logic                  cpu_ready, cpu_err;
   logic [NUM_DEV-1:0]    dev_sel, dev_we;
   logic [31:0]           dev_addr, dev_wdata;
   logic [NUM_DEV*32-1:0] dev_rdata;
   logic [NUM_DEV-1:0]    dev_ready;
   logic [NUM_IRQ-1:0]    irq_in, hwint_out;

   always #5 clk = ~clk;

   sys_bridge #(
      .NUM_DEV (NUM_DEV), .BASE_ADDR (BASE), .WIN_BITS (WIN_BITS),
      .NUM_IRQ (NUM_IRQ), .TIMEOUT (TIMEOUT)
   ) dut (
      .clk (clk), .reset (reset),
      .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata), .cpu_ready (cpu_ready), .cpu_err (cpu_err),
      .dev_sel (dev_sel), .dev_we (dev_we), .dev_addr (dev_addr), .dev_wdata (dev_wdata),
      .dev_rdata (dev_rdata), .dev_ready (dev_ready),
      .irq_in (irq_in), .hwint_out (hwint_out)
   );

   int n_vec = 0;
   int n_err = 0;

   // ---------------- transaction-level reference model ----------------
   int                 cyc = 0;
   bit                 busy = 1'b0, t_mapped = 1'b0, t_we = 1'b0, resp_known = 1'b0;
   int                 t_idx = 0, resp_cyc = 0, acc_n = 0;
   logic [31:0]        e_rdata = 32'h0, e_addr = 32'h0, e_wdata = 32'h0;
   logic               e_err = 1'b0;
   logic [NUM_IRQ-1:0] e_hw = '0;

   // window number of an address, -1 when it falls outside every window
   function automatic int win_of(input logic [31:0] a);
      logic [31:0] off;
      if (a < BASE) return -1;
      off = a - BASE;
      if (off >= (32'(NUM_DEV) << WIN_BITS)) return -1;
      return int'(off >> WIN_BITS);
   endfunction

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      e_hw <= reset ? '0 : irq_in;
      if (reset) begin
         busy <= 1'b0; resp_known <= 1'b0;
         e_rdata <= 32'h0; e_err <= 1'b0; e_addr <= 32'h0; e_wdata <= 32'h0;
      end else if (!busy) begin
         if (cpu_req) begin
            busy <= 1'b1; t_we <= cpu_we; acc_n <= 0;
            e_addr <= cpu_addr; e_wdata <= cpu_wdata;
            if (win_of(cpu_addr) >= 0) begin
               t_mapped <= 1'b1; t_idx <= win_of(cpu_addr); resp_known <= 1'b0;
            end else begin
               t_mapped <= 1'b0; resp_known <= 1'b1; resp_cyc <= cyc + 1;
               e_rdata <= 32'h0; e_err <= 1'b1;
            end
         end
      end else if (!resp_known) begin
         if (dev_ready[t_idx]) begin
            resp_known <= 1'b1; resp_cyc <= cyc + 1; e_err <= 1'b0;
            e_rdata <= t_we ? 32'h0 : dev_rdata[t_idx*32 +: 32];
`ifdef BRIDGE_TIMEOUT_EN
         end else if (acc_n + 1 == TIMEOUT) begin
            resp_known <= 1'b1; resp_cyc <= cyc + 1; e_err <= 1'b1; e_rdata <= 32'h0;
`endif
         end else begin
            acc_n <= acc_n + 1;
         end
      end else if (cyc == resp_cyc) begin
         busy <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [NUM_DEV-1:0] exp_sel();
      logic [NUM_DEV-1:0] one;
      one = {{(NUM_DEV-1){1'b0}}, 1'b1};
      return (busy && t_mapped && !resp_known) ? (one << t_idx) : {NUM_DEV{1'b0}};
   endfunction

   // compare process: every output against the model, mid-cycle
   always @(negedge clk) begin
      if (cyc >= 1) begin
         chk("dev_sel",   32'(dev_sel),   32'(exp_sel()));
         chk("dev_we",    32'(dev_we),    32'(exp_sel() & {NUM_DEV{t_we}}));
         chk("dev_addr",  dev_addr,       e_addr);
         chk("dev_wdata", dev_wdata,      e_wdata);
         chk("cpu_ready", 32'(cpu_ready), 32'(busy && resp_known && cyc == resp_cyc));
         chk("cpu_rdata", cpu_rdata,      e_rdata);
         chk("cpu_err",   32'(cpu_err),   32'(e_err));
         chk("hwint_out", 32'(hwint_out), 32'(e_hw));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      tick();
      cpu_req = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      dev_rdata = '0; dev_ready = '0; irq_in = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_ready", 32'(cpu_ready), 32'h0);
      chk("rst_sel",   32'(dev_sel),   32'h0);
      chk("rst_rdata", cpu_rdata,      32'h0);

      // interrupt pass-through, one cycle late
      irq_in = 6'b100001; tick();
      chk("irq_a", 32'(hwint_out), 32'h21);
      irq_in = 6'b010010; tick();
      chk("irq_b", 32'(hwint_out), 32'h12);
      irq_in = 6'b000000;

      // write 0x7F04 to device 0, ready immediately
      issue(1'b1, 32'h0000_7F04, 32'h0000_1234);
      dev_ready = 2'b01;
      chk("w0_sel",   32'(dev_sel), 32'h1);
      chk("w0_we",    32'(dev_we),  32'h1);
      chk("w0_wdata", dev_wdata,    32'h0000_1234);
      tick();
      dev_ready = 2'b00;
      chk("w0_ready", 32'(cpu_ready), 32'h1);
      chk("w0_err",   32'(cpu_err),   32'h0);
      tick();

      // read device 0 with one wait cycle
      issue(1'b0, 32'h0000_7F08, 32'h0);
      dev_rdata = {32'h1111_2222, 32'h0BAD_F00D};
      tick();
      dev_ready = 2'b01; tick();
      dev_ready = 2'b00;
      chk("r0_rdata", cpu_rdata, 32'h0BAD_F00D);
      tick();

      // write device 1 with two wait cycles
      issue(1'b1, 32'h0000_7F1C, 32'hA5A5_0003);
      chk("w1_we", 32'(dev_we), 32'h2);
      tick();
      tick();
      dev_ready = 2'b10; tick();
      dev_ready = 2'b00;
      chk("w1_rdata", cpu_rdata, 32'h0);
      tick();

      // read 0x7F14: unselected ready and a stray request are both ignored
      issue(1'b0, 32'h0000_7F14, 32'h0);
      dev_rdata = {32'hCAFE_0001, 32'hDEAD_BEEF};
      dev_ready = 2'b01; tick();
      cpu_req = 1'b1; cpu_addr = 32'h0000_7F20; tick();
      cpu_req = 1'b0; cpu_addr = 32'h0000_7F14;
      chk("r1_addr", dev_addr, 32'h0000_7F14);
      tick();
      dev_ready = 2'b10; tick();
      dev_ready = 2'b00;
      chk("r1_ready", 32'(cpu_ready), 32'h1);
      chk("r1_rdata", cpu_rdata,      32'hCAFE_0001);
      chk("r1_we",    32'(dev_we),    32'h0);
      tick();
      chk("r1_pulse", 32'(cpu_ready), 32'h0);
      chk("r1_hold",  cpu_rdata,      32'hCAFE_0001);

      // unmapped read
      issue(1'b0, 32'h0000_7F20, 32'h0);
      chk("um_ready", 32'(cpu_ready), 32'h1);
      chk("um_err",   32'(cpu_err),   32'h1);
      chk("um_rdata", cpu_rdata,      32'h0);
      chk("um_sel",   32'(dev_sel),   32'h0);
      tick();

      // device 0 never answers
      issue(1'b0, 32'h0000_7F00, 32'h0000_00EE);
      for (int i = 1; i <= 20; i++) begin
`ifdef BRIDGE_TIMEOUT_EN
         if (i == TIMEOUT + 1) begin
            chk("to_ready", 32'(cpu_ready), 32'h1);
            chk("to_err",   32'(cpu_err),   32'h1);
            chk("to_rdata", cpu_rdata,      32'h0);
         end
`else
         chk("to_wait_sel",   32'(dev_sel),   32'h1);
         chk("to_wait_ready", 32'(cpu_ready), 32'h0);
`endif
         tick();
      end

      // reset in the middle of an access
`ifdef BRIDGE_TIMEOUT_EN
      issue(1'b0, 32'h0000_7F10, 32'h0000_00EE);
      tick();
`endif
      reset = 1'b1; tick();
      reset = 1'b0;
      chk("ra_sel",   32'(dev_sel),   32'h0);
      chk("ra_addr",  dev_addr,       32'h0);
      chk("ra_wdata", dev_wdata,      32'h0);
      chk("ra_ready", 32'(cpu_ready), 32'h0);
      chk("ra_err",   32'(cpu_err),   32'h0);
      tick(); tick();

      // fresh request after the abort
      issue(1'b0, 32'h0000_7F18, 32'h0);
      dev_rdata = {32'h5555_AAAA, 32'h0};
      dev_ready = 2'b10; tick();
      dev_ready = 2'b00;
      chk("post_ready", 32'(cpu_ready), 32'h1);
      chk("post_rdata", cpu_rdata,      32'h5555_AAAA);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
